// File: rtl/func_rr_sched_pkg.sv
// Shared definitions for the round-robin function-unit scheduler.
// Contents:
//   sched_state_t - scheduler FSM states
//   TMO_DEFAULT   - default watchdog limit, in cycles
//   TMO_CNT_W     - width of the watchdog counter
//   idx_w()       - index width needed to address n requesters
package func_rr_sched_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      RESP      = 3'd4
   } sched_state_t;

   localparam int TMO_DEFAULT = 255;
   localparam int TMO_CNT_W   = 8;

   // At least one bit, even for a single requester.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin priority search.
// Starting at ptr and wrapping modulo NREQ, the first set bit of req wins.
// Ports:
//   req          in  NREQ  request vector
//   ptr          in  IW    index that has the highest priority
//   grant_onehot out NREQ  one-hot winner (all zero when no request)
//   grant_idx    out IW    binary index of the winner (0 when no request)
//   grant_valid  out 1     at least one request is set
module rr_arbiter_onehot
   import func_rr_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant_onehot,
   output logic [IW-1:0]   grant_idx,
   output logic            grant_valid
);

   logic [IW-1:0] cand;

   // Walk from the farthest candidate back to ptr itself, so the candidate
   // closest to ptr is the last one written and therefore wins.
   always_comb begin
      grant_onehot = '0;
      grant_idx    = '0;
      grant_valid  = 1'b0;
      cand         = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = IW'((int'(ptr) + i) % NREQ);
         if (req[cand]) begin
            grant_onehot       = '0;
            grant_onehot[cand] = 1'b1;
            grant_idx          = cand;
            grant_valid        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/func_rr_sched.sv
// Round-robin scheduler sharing one multi-cycle function unit among NREQ
// requesters. The unit uses a start/busy handshake; a watchdog turns a hung
// unit into an error response.
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-low reset
//   req_valid_i/a_i/b_i   per-requester request and packed operands
//   req_ready_o           one-hot acceptance pulse
//   resp_valid_o          one-hot response pulse
//   resp_y_o, resp_err_o  result and timeout flag, qualified by resp_valid_o
//   unit_a_o/b_o/start_o  operands and start strobe to the unit
//   unit_busy_i, unit_y_i busy flag and result from the unit
//   sched_busy_o          high whenever the scheduler is not idle
module func_rr_sched
   import func_rr_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DW   = 8,
   parameter int YW   = 5,
   parameter int TMO  = TMO_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NREQ-1:0]   req_valid_i,
   input  logic [NREQ*DW-1:0] req_a_i,
   input  logic [NREQ*DW-1:0] req_b_i,
   output logic [NREQ-1:0]   req_ready_o,
   output logic [NREQ-1:0]   resp_valid_o,
   output logic [YW-1:0]     resp_y_o,
   output logic              resp_err_o,
   output logic [DW-1:0]     unit_a_o,
   output logic [DW-1:0]     unit_b_o,
   output logic              unit_start_o,
   input  logic              unit_busy_i,
   input  logic [YW-1:0]     unit_y_i,
   output logic              sched_busy_o
);

   localparam int IW = idx_w(NREQ);

   sched_state_t         state, state_next;
   logic [IW-1:0]        ptr, ptr_next, grant_reg, grant_idx;
   logic [NREQ-1:0]      grant_onehot;
   logic                 grant_valid, take, tmo_hit, err_flag;
   logic [DW-1:0]        a_reg, b_reg;
   logic [DW-1:0]        a_slice [NREQ];
   logic [DW-1:0]        b_slice [NREQ];
   logic [TMO_CNT_W-1:0] tmo_cnt;

   rr_arbiter_onehot #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .req          (req_valid_i),
      .ptr          (ptr),
      .grant_onehot (grant_onehot),
      .grant_idx    (grant_idx),
      .grant_valid  (grant_valid)
   );

   // Unpack the operand buses so the winner can be selected by index.
   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         a_slice[k] = req_a_i[k*DW +: DW];
         b_slice[k] = req_b_i[k*DW +: DW];
      end
   end

   // A busy unit in IDLE belongs to someone else (e.g. BIST), so hold off.
   assign take     = (state == IDLE) && grant_valid && !unit_busy_i;
   assign ptr_next = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
   assign tmo_hit  = (tmo_cnt == TMO_CNT_W'(TMO));

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Grant capture, rotating pointer and watchdog. The counter is cleared
   // on the grant edge so it starts from zero when ISSUE is entered.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ptr       <= '0;
         grant_reg <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         tmo_cnt   <= '0;
         err_flag  <= 1'b0;
      end else if (take) begin
         ptr       <= ptr_next;
         grant_reg <= grant_idx;
         a_reg     <= a_slice[grant_idx];
         b_reg     <= b_slice[grant_idx];
         tmo_cnt   <= '0;
         err_flag  <= 1'b0;
      end else if ((state == WAIT_BUSY) || (state == WAIT_DONE)) begin
         if (tmo_hit) begin
            err_flag <= 1'b1;
         end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
      end
   end

   // Next-state and output decode. The watchdog has priority over the
   // handshake so a hung unit always ends in an error response.
   // req_ready_o is gated by reset because IDLE is also the reset state.
   always_comb begin
      state_next   = state;
      req_ready_o  = '0;
      resp_valid_o = '0;
      resp_y_o     = '0;
      resp_err_o   = 1'b0;
      unit_start_o = 1'b0;
      unit_a_o     = a_reg;
      unit_b_o     = b_reg;
      sched_busy_o = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (take) begin
               req_ready_o = rst_i ? grant_onehot : '0;
               state_next  = ISSUE;
            end
         end
         ISSUE: begin
            unit_start_o = 1'b1;
            state_next   = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tmo_hit) begin
               state_next = RESP;
            end else if (unit_busy_i) begin
               state_next = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (tmo_hit || !unit_busy_i) begin
               state_next = RESP;
            end
         end
         RESP: begin
            resp_valid_o[grant_reg] = 1'b1;
            resp_err_o              = err_flag;
            resp_y_o                = err_flag ? '0 : unit_y_i;
            state_next              = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: doc/func_rr_sched.md
Name: func_rr_sched

Overview:
- Round-robin scheduler that shares one multi-cycle function unit among NREQ requesters.
- The unit computes y = floor(sqrt(a + floor(cbrt(b)))) and uses a start/busy handshake.
- Accepts one operand pair at a time, drives the unit's start/busy protocol, and routes the 5-bit result back to the winning requester.
- Adds a busy-timeout watchdog. Sits between user-side clients and the func unit / BIST wrapper.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, operand width for a and b.
- YW, 5, result width.
- TMO, 255, maximum cycles allowed in WAIT_BUSY plus WAIT_DONE before the error path (8-bit counter).

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  NREQ  per-requester request; held until accepted.
- req_a_i  in  NREQ*DW  packed operand a; slice k belongs to requester k.
- req_b_i  in  NREQ*DW  packed operand b.
- req_ready_o  out  NREQ  one-hot, 1-cycle pulse: request k accepted this cycle.
- resp_valid_o  out  NREQ  one-hot, 1-cycle pulse: result for requester k.
- resp_y_o  out  YW  result; valid only while resp_valid_o != 0.
- resp_err_o  out  1  qualifies resp_valid_o; 1 = unit timed out, resp_y_o = 0.
- unit_a_o  out  DW  operand a to unit.
- unit_b_o  out  DW  operand b to unit.
- unit_start_o  out  1  start strobe to unit.
- unit_busy_i  in  1  unit busy.
- unit_y_i  in  YW  unit result.
- sched_busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_i = 0, async): state IDLE, rr pointer = 0, all outputs 0, operand registers 0, timeout counter 0.
- Arbitration in IDLE: if any req_valid_i is set, grant the first set bit searching from ptr upward, wrapping modulo NREQ.
  - Capture that requester's a/b into the operand registers.
  - Pulse req_ready_o[g] in the same cycle.
  - Set ptr = (g+1) mod NREQ.
  - Go to ISSUE.
- ISSUE (1 cycle): unit_start_o = 1; unit_a_o / unit_b_o are driven from the registers and stay stable until IDLE. Go to WAIT_BUSY.
- WAIT_BUSY: unit_start_o = 0.
  - Wait for unit_busy_i = 1, then go to WAIT_DONE.
  - If the unit has already finished (busy never observed high) the watchdog catches it; the unit must raise busy within TMO cycles.
- WAIT_DONE: wait for unit_busy_i = 0, then go to RESP.
- RESP (1 cycle): resp_valid_o[g] = 1, resp_y_o = unit_y_i sampled in this cycle, resp_err_o = 0. Go to IDLE.
- Watchdog:
  - The counter clears on entry to ISSUE and increments in WAIT_BUSY and WAIT_DONE.
  - When it reaches TMO, go to RESP with resp_err_o = 1 and resp_y_o = 0, then IDLE.
  - No retry.
- Latency: from request sampled in IDLE to resp_valid_o = 3 + (unit busy-rise delay) + (busy duration) cycles.
  - No new grant is made in the RESP cycle; the next grant is possible in the cycle after RESP.
- Requests are ignored outside IDLE.
  - req_valid_i may drop before acceptance; no grant is issued for it.
  - Operand changes after acceptance have no effect.
- Fairness: with all NREQ requesters continuously valid, grants cycle 0,1,..,NREQ-1,0.
  - No requester waits more than NREQ-1 other transactions.
- unit_busy_i high while in IDLE (e.g. the BIST wrapper owns the unit): no grant until unit_busy_i = 0.
- Reset mid-transaction: return to IDLE immediately; the in-flight result is discarded and no response is issued.

Decomposition:
- Shared package: state encoding (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP) and the default TMO constant.
- One sub-module, rr_arbiter_onehot: combinational priority search from ptr, NREQ-wide.
  - Outputs grant_onehot and grant_idx.
  - Reusable by later multi-client blocks.

Test Plan:
- Reset, then requester 0 sends a=12, b=60 -> req_ready_o = 0001 once, unit_start_o pulses once with a=12/b=60, resp_valid_o = 0001, resp_y_o = 3, err = 0.
- Requesters 0..3 all valid with (123,223), (255,255), (30,255), (45,64) -> grant order 0,1,2,3; responses 11, 16, 6, 7 on matching resp_valid_o bits.
- Requesters 1 and 3 continuously valid with 8 transactions each -> strict alternation 1,3,1,3; each response stays tied to its requester.
- Unit model never raises busy -> after TMO cycles, resp_valid_o pulses with resp_err_o = 1 and resp_y_o = 0; the next request is served normally.
- unit_busy_i forced high in IDLE while requester 2 is valid -> no req_ready_o; release busy -> grant 2, result correct (e.g. a=1, b=255 -> y=2).
- Assert reset during WAIT_DONE -> all outputs 0, no resp_valid_o; the following request (a=255, b=1) returns 16.
